// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU operation enum,
// branch encodings and the control bundle produced by decode_ctrl.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;

    typedef enum logic [4:0] {
        ALU_NOP, ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU, ALU_AND, ALU_OR,
        ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_LUI, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO
    } alu_op_t;

    typedef struct packed {
        alu_op_t    alu_op;
        logic       use_imm;
        logic       reg_write;
        logic       hilo_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{alu_op: ALU_NOP, use_imm: 1'b0,
        reg_write: 1'b0, hilo_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        branch: BR_NONE, jump: 1'b0, illegal: 1'b0};

    localparam ctrl_t CTRL_ILLEGAL = '{alu_op: ALU_NOP, use_imm: 1'b0,
        reg_write: 1'b0, hilo_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        branch: BR_NONE, jump: 1'b0, illegal: 1'b1};

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle; the slave
// modport is the decode stage, the master modport the surrounding pipeline.
interface decode_if
    import decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_insn;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    alu_op_t           out_alu_op;
    logic [REG_AW-1:0] out_rs;
    logic [REG_AW-1:0] out_rt;
    logic [REG_AW-1:0] out_rd;
    logic [4:0]        out_sa;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_target;
    logic              out_use_imm;
    logic              out_reg_write;
    logic              out_hilo_write;
    logic              out_mem_read;
    logic              out_mem_write;
    logic [1:0]        out_branch;
    logic              out_jump;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_alu_op, out_rs, out_rt,
               out_rd, out_sa, out_imm, out_target, out_use_imm,
               out_reg_write, out_hilo_write, out_mem_read, out_mem_write,
               out_branch, out_jump, out_illegal
    );

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_alu_op, out_rs, out_rt,
               out_rd, out_sa, out_imm, out_target, out_use_imm,
               out_reg_write, out_hilo_write, out_mem_read, out_mem_write,
               out_branch, out_jump, out_illegal
    );
endinterface

// File: rtl/decode_ctrl.sv
// Combinational MIPS decoder: instruction word and PC in, control bundle,
// register indices, extended immediate and branch/jump target out.
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic [31:0]       insn,
    input  logic [XLEN-1:0]   pc,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt,
    output logic [REG_AW-1:0] rd,
    output logic [4:0]        sa,
    output logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   target
);
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] sext_imm;

    assign opcode   = insn[31:26];
    assign funct    = insn[5:0];
    assign pc4      = pc + XLEN'(4);
    assign sext_imm = XLEN'($signed(insn[15:0]));

    always_comb begin
        ctrl   = CTRL_NONE;
        rs     = REG_AW'(insn[25:21]);
        rt     = REG_AW'(insn[20:16]);
        rd     = REG_AW'(insn[15:11]);
        sa     = insn[10:6];
        imm    = sext_imm;
        target = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case (funct)
                    F_ADD:  ctrl.alu_op = ALU_ADD;
                    F_ADDU: ctrl.alu_op = ALU_ADDU;
                    F_SUB:  ctrl.alu_op = ALU_SUB;
                    F_SUBU: ctrl.alu_op = ALU_SUBU;
                    F_AND:  ctrl.alu_op = ALU_AND;
                    F_OR:   ctrl.alu_op = ALU_OR;
                    F_XOR:  ctrl.alu_op = ALU_XOR;
                    F_NOR:  ctrl.alu_op = ALU_NOR;
                    F_SLT:  ctrl.alu_op = ALU_SLT;
                    F_SLTU: ctrl.alu_op = ALU_SLTU;
                    F_SLL, F_SLLV: ctrl.alu_op = ALU_SLL;
                    F_SRL, F_SRLV: ctrl.alu_op = ALU_SRL;
                    F_SRA, F_SRAV: ctrl.alu_op = ALU_SRA;
                    F_MFHI: ctrl.alu_op = ALU_MFHI;
                    F_MFLO: ctrl.alu_op = ALU_MFLO;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        ctrl.reg_write  = 1'b0;
                        ctrl.hilo_write = 1'b1;
                        case (funct)
                            F_MULT:  ctrl.alu_op = ALU_MULT;
                            F_MULTU: ctrl.alu_op = ALU_MULTU;
                            F_DIV:   ctrl.alu_op = ALU_DIV;
                            default: ctrl.alu_op = ALU_DIVU;
                        endcase
                    end
                    default: ctrl = CTRL_ILLEGAL;
                endcase
            end
            // I-type ALU ops and loads write rt; memory ops use ADD for the address
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI, OP_LW: begin
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
                rd             = REG_AW'(insn[20:16]);
                case (opcode)
                    OP_ADDI:  ctrl.alu_op = ALU_ADD;
                    OP_ADDIU: ctrl.alu_op = ALU_ADDU;
                    OP_SLTI:  ctrl.alu_op = ALU_SLT;
                    OP_SLTIU: ctrl.alu_op = ALU_SLTU;
                    OP_ANDI: begin
                        ctrl.alu_op = ALU_AND;
                        imm         = XLEN'(insn[15:0]);
                    end
                    OP_ORI: begin
                        ctrl.alu_op = ALU_OR;
                        imm         = XLEN'(insn[15:0]);
                    end
                    OP_XORI: begin
                        ctrl.alu_op = ALU_XOR;
                        imm         = XLEN'(insn[15:0]);
                    end
                    OP_LUI: begin
                        ctrl.alu_op = ALU_LUI;
                        imm         = XLEN'($signed({insn[15:0], 16'h0000}));
                    end
                    default: begin
                        ctrl.alu_op   = ALU_ADD;
                        ctrl.mem_read = 1'b1;
                    end
                endcase
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.use_imm   = 1'b1;
                ctrl.mem_write = 1'b1;
                rd             = REG_AW'(insn[20:16]);
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                target      = pc4 + (sext_imm << 2);
            end
            OP_J, OP_JAL: begin
                ctrl.jump = 1'b1;
                target    = {pc4[XLEN-1:28], insn[25:0], 2'b00};
                if (opcode == OP_JAL) begin
                    ctrl.reg_write = 1'b1;
                    rd             = REG_AW'(LINK_REG);
                end
            end
            default: ctrl = CTRL_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage with a two-entry elastic buffer (output + skid).
// Optional macro DECODE_TRACE_EN prints each bundle as it leaves the stage.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    decode_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        ctrl_t             ctrl;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [4:0]        sa;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   target;
    } bundle_t;

    ctrl_t             dec_ctrl;
    logic [REG_AW-1:0] dec_rs, dec_rt, dec_rd;
    logic [4:0]        dec_sa;
    logic [XLEN-1:0]   dec_imm, dec_target;
    bundle_t           dec, out_q, skid_q;
    logic              out_valid_q, skid_valid_q;
    logic              accept;

    decode_ctrl #(
        .XLEN     (XLEN),
        .REG_AW   (REG_AW),
        .LINK_REG (LINK_REG)
    ) u_ctrl (
        .insn   (bus.in_insn),
        .pc     (bus.in_pc),
        .ctrl   (dec_ctrl),
        .rs     (dec_rs),
        .rt     (dec_rt),
        .rd     (dec_rd),
        .sa     (dec_sa),
        .imm    (dec_imm),
        .target (dec_target)
    );

    assign dec = '{pc: bus.in_pc, ctrl: dec_ctrl, rs: dec_rs, rt: dec_rt,
                   rd: dec_rd, sa: dec_sa, imm: dec_imm, target: dec_target};

    assign bus.in_ready = !skid_valid_q;
    assign accept       = bus.in_valid && !skid_valid_q;

    // Skid always refills the output slot before a new input may enter,
    // which keeps program order without a comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_q <= dec;
                end
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_q.pc;
    assign bus.out_alu_op     = out_q.ctrl.alu_op;
    assign bus.out_rs         = out_q.rs;
    assign bus.out_rt         = out_q.rt;
    assign bus.out_rd         = out_q.rd;
    assign bus.out_sa         = out_q.sa;
    assign bus.out_imm        = out_q.imm;
    assign bus.out_target     = out_q.target;
    assign bus.out_use_imm    = out_q.ctrl.use_imm;
    assign bus.out_reg_write  = out_q.ctrl.reg_write;
    assign bus.out_hilo_write = out_q.ctrl.hilo_write;
    assign bus.out_mem_read   = out_q.ctrl.mem_read;
    assign bus.out_mem_write  = out_q.ctrl.mem_write;
    assign bus.out_branch     = out_q.ctrl.branch;
    assign bus.out_jump       = out_q.ctrl.jump;
    assign bus.out_illegal    = out_q.ctrl.illegal;

`ifdef DECODE_TRACE_EN
    // Mnemonic is rebuilt from the control bundle; the raw word is not kept.
    always @(posedge clk) begin
        string mnem;
        if (rst_n && out_valid_q && bus.out_ready) begin
            if (out_q.ctrl.illegal) begin
                $display("ILLEGAL %h", out_q.pc);
            end else begin
                if (out_q.ctrl.jump)
                    mnem = out_q.ctrl.reg_write ? "JAL" : "J";
                else if (out_q.ctrl.branch == BR_BEQ)
                    mnem = "BEQ";
                else if (out_q.ctrl.branch == BR_BNE)
                    mnem = "BNE";
                else if (out_q.ctrl.mem_read)
                    mnem = "LW";
                else if (out_q.ctrl.mem_write)
                    mnem = "SW";
                else
                    mnem = out_q.ctrl.alu_op.name();
                $display("pc=%h %s %0d %0d %0d %h", out_q.pc, mnem,
                         out_q.rs, out_q.rt, out_q.rd, out_q.imm);
            end
        end
    end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode vectors,
// back-pressure through the skid buffer, flush and asynchronous reset.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    decode_if #(.XLEN(32), .REG_AW(5)) bus ();

    decode_stage #(.XLEN(32), .REG_AW(5), .LINK_REG(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] insn,
                                 input logic [31:0] pc, input logic ready);
        bus.in_valid  = valid;
        bus.in_insn   = insn;
        bus.in_pc     = pc;
        bus.out_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_alu_op", 32'(bus.out_alu_op), 32'd0);
        checkOutput("rst_imm", bus.out_imm, 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 32'h00221820, 32'h0000_0000, 1'b1);
        tick();
        checkOutput("add_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("add_alu", 32'(bus.out_alu_op), 32'(ALU_ADD));
        checkOutput("add_rs", 32'(bus.out_rs), 32'd1);
        checkOutput("add_rt", 32'(bus.out_rt), 32'd2);
        checkOutput("add_rd", 32'(bus.out_rd), 32'd3);
        checkOutput("add_wr", 32'(bus.out_reg_write), 32'd1);
        checkOutput("add_useimm", 32'(bus.out_use_imm), 32'd0);

        applyStimulus(1'b1, 32'h2005FFFC, 32'h0000_0004, 1'b1);
        tick();
        checkOutput("addi_imm", bus.out_imm, 32'hFFFF_FFFC);
        checkOutput("addi_rd", 32'(bus.out_rd), 32'd5);
        checkOutput("addi_useimm", 32'(bus.out_use_imm), 32'd1);
        checkOutput("addi_pc", bus.out_pc, 32'h0000_0004);

        applyStimulus(1'b1, 32'h3405FFFC, 32'h0000_0008, 1'b1);
        tick();
        checkOutput("ori_imm", bus.out_imm, 32'h0000_FFFC);
        checkOutput("ori_alu", 32'(bus.out_alu_op), 32'(ALU_OR));

        applyStimulus(1'b1, 32'h1000FFFF, 32'h0000_0100, 1'b1);
        tick();
        checkOutput("beq_branch", 32'(bus.out_branch), 32'd1);
        checkOutput("beq_target", bus.out_target, 32'h0000_0100);
        checkOutput("beq_wr", 32'(bus.out_reg_write), 32'd0);

        applyStimulus(1'b1, 32'h08000040, 32'h0040_0000, 1'b1);
        tick();
        checkOutput("j_target", bus.out_target, 32'h0000_0100);
        checkOutput("j_jump", 32'(bus.out_jump), 32'd1);
        checkOutput("j_wr", 32'(bus.out_reg_write), 32'd0);

        applyStimulus(1'b1, 32'h0C000040, 32'h0000_0000, 1'b1);
        tick();
        checkOutput("jal_rd", 32'(bus.out_rd), 32'd31);
        checkOutput("jal_wr", 32'(bus.out_reg_write), 32'd1);
        checkOutput("jal_target", bus.out_target, 32'h0000_0100);

        applyStimulus(1'b1, 32'h8C450008, 32'h0000_0010, 1'b1);
        tick();
        checkOutput("lw_rd", 32'(bus.out_rd), 32'd5);
        checkOutput("lw_mem_read", 32'(bus.out_mem_read), 32'd1);
        checkOutput("lw_wr", 32'(bus.out_reg_write), 32'd1);

        applyStimulus(1'b1, 32'hAC450008, 32'h0000_0014, 1'b1);
        tick();
        checkOutput("sw_mem_write", 32'(bus.out_mem_write), 32'd1);
        checkOutput("sw_wr", 32'(bus.out_reg_write), 32'd0);

        applyStimulus(1'b1, 32'h3C058000, 32'h0000_0018, 1'b1);
        tick();
        checkOutput("lui_imm", bus.out_imm, 32'h8000_0000);
        checkOutput("lui_alu", 32'(bus.out_alu_op), 32'(ALU_LUI));

        applyStimulus(1'b1, 32'h00430018, 32'h0000_001C, 1'b1);
        tick();
        checkOutput("mult_hilo", 32'(bus.out_hilo_write), 32'd1);
        checkOutput("mult_wr", 32'(bus.out_reg_write), 32'd0);

        applyStimulus(1'b1, 32'hFC000000, 32'h0000_0020, 1'b1);
        tick();
        checkOutput("illop_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("illop_flag", 32'(bus.out_illegal), 32'd1);
        checkOutput("illop_wr", 32'(bus.out_reg_write), 32'd0);
        checkOutput("illop_mem", 32'({bus.out_mem_read, bus.out_mem_write}), 32'd0);
        checkOutput("illop_alu", 32'(bus.out_alu_op), 32'(ALU_NOP));

        applyStimulus(1'b1, 32'h0000003F, 32'h0000_0024, 1'b1);
        tick();
        checkOutput("illfn_flag", 32'(bus.out_illegal), 32'd1);
        checkOutput("illfn_wr", 32'(bus.out_reg_write), 32'd0);

        applyStimulus(1'b1, 32'h00000000, 32'h0000_0028, 1'b1);
        tick();
        checkOutput("nop_alu", 32'(bus.out_alu_op), 32'(ALU_SLL));
        checkOutput("nop_illegal", 32'(bus.out_illegal), 32'd0);

        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("idle_valid", 32'(bus.out_valid), 32'd0);

        // back-pressure: three instructions with execute stalled for three edges
        applyStimulus(1'b1, 32'h00221820, 32'h0000_0040, 1'b0);
        tick();
        checkOutput("bp1_pc", bus.out_pc, 32'h0000_0040);
        checkOutput("bp1_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 32'h3405FFFC, 32'h0000_0044, 1'b0);
        tick();
        checkOutput("bp2_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("bp2_pc", bus.out_pc, 32'h0000_0040);
        applyStimulus(1'b1, 32'h2005FFFC, 32'h0000_0048, 1'b0);
        tick();
        checkOutput("bp3_pc", bus.out_pc, 32'h0000_0040);
        checkOutput("bp3_alu", 32'(bus.out_alu_op), 32'(ALU_ADD));
        checkOutput("bp3_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(1'b1, 32'h2005FFFC, 32'h0000_0048, 1'b1);
        tick();
        checkOutput("bp4_pc", bus.out_pc, 32'h0000_0044);
        checkOutput("bp4_alu", 32'(bus.out_alu_op), 32'(ALU_OR));
        checkOutput("bp4_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("bp5_pc", bus.out_pc, 32'h0000_0048);
        checkOutput("bp5_imm", bus.out_imm, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("bp6_valid", 32'(bus.out_valid), 32'd0);

        // flush with both entries occupied and a new instruction offered
        applyStimulus(1'b1, 32'h00221820, 32'h0000_0080, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h3405FFFC, 32'h0000_0084, 1'b0);
        tick();
        checkOutput("fl_full", 32'(bus.in_ready), 32'd0);
        flush = 1'b1;
        applyStimulus(1'b1, 32'h2005FFFC, 32'h0000_0088, 1'b0);
        tick();
        flush = 1'b0;
        checkOutput("fl_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("fl_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("fl_empty", 32'(bus.out_valid), 32'd0);

        // asynchronous reset while a bundle is held
        applyStimulus(1'b1, 32'h00221820, 32'h0000_00C0, 1'b0);
        tick();
        checkOutput("ar_before", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("ar_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("ar_pc", bus.out_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("ar_after", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
